shift_queue_ctrl: RTL and testbench
===================================

// Module: shift_queue_ctrl
// PURPOSE
//   Controls a chain of DEPTH register_stage instances used as a shift-register FIFO.
//   Two producers share the single fill port through a round-robin arbiter.
//   The block generates the chain's shift_in, shift_out and fill_in signals.
//   It tracks occupancy, drives the consumer valid/ready handshake and runs a drain-based flush.
//   Instantiated next to the stage chain. Last stage's next_filled tied 1, stage 0's prev_filled tied 0.
// PARAMETERS
//   WIDTH   32  data width of requester payload / stage fill_in
//   DEPTH   8   number of register stages in the controlled chain (>=2)
//   CNT_W   4   occupancy counter width, must hold DEPTH (>= clog2(DEPTH+1))
// PORTS
//   clk          in   1      clock, all state on rising edge
//   res          in   1      synchronous, active-high reset
//   req0_valid   in   1      requester 0 has data
//   req0_data    in   WIDTH  requester 0 payload
//   req0_ready   out  1      requester 0 push accepted this cycle
//   req1_valid   in   1      requester 1 has data
//   req1_data    in   WIDTH  requester 1 payload
//   req1_ready   out  1      requester 1 push accepted this cycle
//   out_valid    out  1      chain's last stage holds valid data
//   out_ready    in   1      consumer takes the last stage this cycle
//   flush        in   1      request to drain the whole chain
//   stg_shift_in out  1      to every stage: fill this cycle
//   stg_shift_out out 1      to every stage: shift forward this cycle
//   stg_fill     out  WIDTH  to every stage fill_in: granted payload
//   count        out  CNT_W  registered occupancy, 0..DEPTH
//   full / empty out  1      count==DEPTH / count==0 (from registered count)
//   busy         out  1      high while in FLUSH
//   flush_done   out  1      one-cycle pulse when FLUSH returns to RUN
// BEHAVIOUR
//   Reset: state=RUN, count=0, rr_ptr=0, flush_done=0. All handshake and stage controls are 0 while res=1.
//   FSM RUN:
//     - push_ok = !full; pop = out_valid & out_ready; out_valid = !empty.
//     - Arbiter: if only one reqN_valid, that one is granted. If both, rr_ptr wins.
//     - reqN_ready = push_ok & grantN (combinational). At most one ready per cycle.
//     - On an accepted push, rr_ptr <= index of the loser. If only one requester was valid, rr_ptr <= the other index.
//     - stg_fill = granted data (req0_data when nothing granted).
//     - stg_shift_in = accepted push; stg_shift_out = pop.
//     - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//     - Full with pop and push both pending: push is NOT accepted (ready low), because a fill at full would lose data. Pop proceeds, count -> DEPTH-1.
//     - Empty: out_valid=0, so out_ready is ignored. A push with out_ready=1 only fills.
//     - flush=1 in RUN: enter FLUSH next cycle. Handshakes in that same cycle complete normally.
//   FSM FLUSH:
//     - reqN_ready=0, out_valid=0, busy=1.
//     - stg_shift_out=1 each cycle while count!=0; count decrements by 1 per cycle.
//     - When count==0: stg_shift_out=0, return to RUN, flush_done=1 for that one cycle.
//     - Entering with count==0 takes exactly one FLUSH cycle. flush is ignored while busy.
//   Latency:
//     - A push accepted in cycle t is visible as out_valid in t+1 when the chain was empty.
//     - Otherwise the pushed word is visible after all older entries are popped.
//   Order: FIFO. Arbitration only decides entry order; it never reorders entries already in the chain.
//   Widths: count never wraps. Underflow or overflow is impossible by construction; the bench asserts this.
//   Reset mid-flush or mid-handshake: state is cleared next edge, no flush_done pulse, no partial counts.
// TESTING
//   1. Reset, no activity -> count=0, empty=1, out_valid=0, all readies 0 during res, stage controls 0.
//   2. req0 pushes 0xA, 0xB, out_ready=0 -> count=2. Then out_ready=1 for 2 cycles -> chain output 0xA then 0xB, empty=1.
//   3. Both valid continuously (0x100.., 0x200..), DEPTH pushes -> grants alternate 0,1,0,1..., full=1, readies 0 at count=8.
//   4. Full with out_ready=1 and req0_valid=1 -> ready low, count 8->7. Next cycle push and pop together -> count stays 7.
//   5. Fill 5 entries, pulse flush -> busy for 6 cycles, 5 stg_shift_out pulses, flush_done one cycle, count=0.
//   6. Assert res during FLUSH at count=3 -> next cycle state RUN, count=0, no flush_done. Chain checked empty by scoreboard.

Source files
------------

// File: rtl/shift_queue_ctrl.sv
// shift_queue_ctrl: controller for a shift-register FIFO chain with two round-robin
// arbitrated producers, occupancy tracking and a drain-based flush.
module shift_queue_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             stg_shift_in,
    output logic             stg_shift_out,
    output logic [WIDTH-1:0] stg_fill,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             flush_done
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rr_q, rr_d;
    logic             run, grant0, grant1, push, pop;
    always_comb begin
        run           = !res && state_q == RUN;
        full          = count_q == CNT_W'(DEPTH);
        empty         = count_q == '0;
        count         = count_q;
        grant0        = req0_valid && (!req1_valid || !rr_q);
        grant1        = req1_valid && !grant0;
        // no push at full: a fill would shift the last stage out before it is consumed
        push          = run && !full && (grant0 || grant1);
        pop           = run && !empty && out_ready;
        req0_ready    = push && grant0;
        req1_ready    = push && grant1;
        out_valid     = run && !empty;
        stg_fill      = grant1 ? req1_data : req0_data;
        stg_shift_in  = push;
        busy          = !res && state_q == FLUSH;
        stg_shift_out = pop || (busy && !empty);
        flush_done    = busy && empty;
        state_d       = state_q;
        count_d       = count_q;
        rr_d          = rr_q;
        if (state_q == RUN) begin
            state_d = flush ? FLUSH : RUN;
            rr_d    = push ? grant0 : rr_q;
            count_d = (push && !pop) ? count_q + CNT_W'(1) :
                      (pop && !push) ? count_q - CNT_W'(1) : count_q;
        end else begin
            state_d = empty ? RUN : FLUSH;
            count_d = empty ? count_q : count_q - CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= RUN;
            count_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_shift_queue_ctrl.sv
// tb_shift_queue_ctrl: directed bench with a cycle model of the controller and a
// data scoreboard standing in for the register-stage chain.
module tb_shift_queue_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             res;
    logic             req0_valid, req1_valid, out_ready, flush;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready, out_valid;
    logic             stg_shift_in, stg_shift_out;
    logic [WIDTH-1:0] stg_fill;
    logic [CNT_W-1:0] count;
    logic             full, empty, busy, flush_done;

    shift_queue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .stg_shift_in(stg_shift_in), .stg_shift_out(stg_shift_out), .stg_fill(stg_fill),
        .count(count), .full(full), .empty(empty), .busy(busy), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int m_cnt = 0;
    bit m_rr = 0;
    bit m_busy = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] chain_q[$];
    logic [WIDTH-1:0] out_log[$];
    logic s_busy, s_so, s_fd, s_r0, s_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, run the chain
    // scoreboard, advance the model, then move to just after the next rising edge.
    task automatic cyc();
        bit g0, g1, push, pop;
        logic [WIDTH-1:0] got, want;
        #4;
        s_busy = busy; s_so = stg_shift_out; s_fd = flush_done;
        s_r0 = req0_ready; s_r1 = req1_ready;
        if (res) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_shift_in", stg_shift_in, 0);
            chk("rst_shift_out", stg_shift_out, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_flush_done", flush_done, 0);
        end else begin
            chk("count", count, m_cnt);
            chk("full", full, m_cnt == DEPTH);
            chk("empty", empty, m_cnt == 0);
            chk("busy", busy, m_busy);
            if (!m_busy) begin
                g0 = req0_valid && (!req1_valid || !m_rr);
                g1 = req1_valid && !g0;
                push = (g0 || g1) && m_cnt != DEPTH;
                pop = m_cnt != 0 && out_ready;
                chk("ready0", req0_ready, push && g0);
                chk("ready1", req1_ready, push && g1);
                chk("out_valid", out_valid, m_cnt != 0);
                chk("shift_in", stg_shift_in, push);
                chk("shift_out", stg_shift_out, pop);
                chk("flush_done", flush_done, 0);
                if (push) begin
                    want = g0 ? req0_data : req1_data;
                    chk("fill", stg_fill, want);
                    exp_q.push_back(want);
                end
            end else begin
                chk("fl_ready0", req0_ready, 0);
                chk("fl_ready1", req1_ready, 0);
                chk("fl_out_valid", out_valid, 0);
                chk("fl_shift_in", stg_shift_in, 0);
                chk("fl_shift_out", stg_shift_out, m_cnt != 0);
                chk("fl_flush_done", flush_done, m_cnt == 0);
            end
        end
        if (stg_shift_in) chain_q.push_back(stg_fill);
        if (stg_shift_out) begin
            chk("chain_underflow", chain_q.size() > 0, 1);
            if (chain_q.size() > 0) begin
                got = chain_q.pop_front();
                if (exp_q.size() > 0) want = exp_q.pop_front();
                else want = 'x;
                if (!busy) begin
                    chk("order", got, want);
                    out_log.push_back(got);
                end
            end
        end
        chk("chain_overflow", chain_q.size() <= DEPTH, 1);
        if (res) begin
            m_cnt = 0; m_rr = 0; m_busy = 0;
            exp_q.delete(); chain_q.delete();
        end else if (!m_busy) begin
            if (push && !pop) m_cnt++;
            if (pop && !push) m_cnt--;
            if (push) m_rr = g0;
            if (flush) m_busy = 1;
        end else if (m_cnt != 0) m_cnt--;
        else m_busy = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_n, so_n, fd_n;
        res = 1; req0_valid = 1; req1_valid = 1; out_ready = 1; flush = 0;
        req0_data = 32'h1; req1_data = 32'h2;
        // reset with activity on every input
        cyc(); cyc();
        res = 0; req0_valid = 0; req1_valid = 0; out_ready = 0;
        cyc();
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1);
        // two pushes from requester 0, then drain in order
        req0_valid = 1; req0_data = 32'hA; cyc();
        req0_data = 32'hB; cyc();
        req0_valid = 0; cyc();
        chk("t2_count", count, 2);
        out_ready = 1; cyc(); cyc();
        out_ready = 0; cyc();
        chk("t2_empty", empty, 1);
        chk("t2_log_n", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("t2_first", out_log[0], 32'hA);
            chk("t2_second", out_log[1], 32'hB);
        end
        // both requesters continuously: grants alternate from 0 after reset
        res = 1; cyc(); res = 0;
        req0_valid = 1; req1_valid = 1; req0_data = 32'h100; req1_data = 32'h200;
        for (int i = 0; i <= DEPTH; i++) begin
            cyc();
            if (i < DEPTH) begin
                chk("t3_grant0", s_r0, (i % 2) == 0);
                chk("t3_grant1", s_r1, (i % 2) == 1);
            end else begin
                chk("t3_full_r0", s_r0, 0);
                chk("t3_full_r1", s_r1, 0);
            end
            if (s_r0) req0_data++;
            if (s_r1) req1_data++;
        end
        chk("t3_full", full, 1);
        // full with pop and push pending: pop only, then both together
        req1_valid = 0; out_ready = 1; req0_data = 32'h150;
        cyc();
        chk("t4_no_push_r0", s_r0, 0);
        chk("t4_count7", count, 7);
        req0_data = 32'h151; cyc();
        chk("t4_r0", s_r0, 1);
        chk("t4_count_hold", count, 7);
        req0_valid = 0;
        for (int i = 0; i < DEPTH; i++) cyc();
        out_ready = 0; cyc();
        chk("t4_drained", empty, 1);
        // fill five then flush
        req1_valid = 1;
        for (int i = 0; i < 5; i++) begin req1_data = 32'h300 + i; cyc(); end
        req1_valid = 0; flush = 1; cyc(); flush = 0;
        busy_n = 0; so_n = 0; fd_n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            busy_n += s_busy; so_n += s_so; fd_n += s_fd;
        end
        chk("t5_busy_cycles", busy_n, 6);
        chk("t5_shift_outs", so_n, 5);
        chk("t5_flush_done", fd_n, 1);
        chk("t5_count", count, 0);
        chk("t5_chain", chain_q.size(), 0);
        // reset in the middle of a flush
        req0_valid = 1;
        for (int i = 0; i < 3; i++) begin req0_data = 32'h400 + i; cyc(); end
        req0_valid = 0; flush = 1; cyc(); flush = 0;
        chk("t6_pre_count", count, 3);
        res = 1; cyc(); res = 0;
        fd_n = 0; busy_n = 0;
        for (int i = 0; i < 3; i++) begin cyc(); fd_n += s_fd; busy_n += s_busy; end
        chk("t6_no_flush_done", fd_n, 0);
        chk("t6_not_busy", busy_n, 0);
        chk("t6_count", count, 0);
        chk("t6_chain", chain_q.size() + exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
